// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and hands each fetched instruction and its PC to IF/ID over a valid/ready handshake.
module if_fetch_unit #(
  parameter int              SIZE     = 64,
  parameter int              INST     = 32,
  parameter logic [SIZE-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [SIZE-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [SIZE-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [INST-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [SIZE-1:0] out_pc,
  output logic [INST-1:0] out_instr,
  input  logic            out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            out_valid_q, out_valid_d;
  logic [SIZE-1:0] out_pc_q, out_pc_d;
  logic [INST-1:0] out_instr_q, out_instr_d;
  logic [SIZE-1:0] redir_pc;
  logic            redir_lo_unused;

  // Targets are word aligned; the low two bits are discarded.
  assign redir_pc        = {redirect_pc[SIZE-1:2], 2'b00};
  assign redir_lo_unused = ^redirect_pc[1:0];

  assign imem_req_valid = (state_q == S_FETCH);
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_instr      = out_instr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (redirect_valid) pc_d = redir_pc;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // The old address was already accepted; its response must be thrown away.
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_rsp_data;
            pc_d        = pc_q + SIZE'(4);
            state_d     = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

endmodule
